loopback_mch: RTL and testbench
===============================

// Module: loopback_mch
// PURPOSE
//  Multi-channel application-side loopback engine behind the usb_cdc app interface.
//  Each channel buffers bulk-OUT bytes in its own FIFO and returns them on a bulk-IN
//  channel selected by ROUTE_OFS, optionally transformed. When a FIFO fills, it
//  back-pressures the OUT stream, and the USB core then NAKs further OUT packets.
//  Single clock domain: the usb_cdc app clock.
// PARAMETERS
//  CHANNELS   2    number of CDC channels, 1..8
//  DEPTH      16   bytes per channel FIFO; power of 2, >=2
//  ROUTE_OFS  0    OUT channel i feeds IN channel (i+ROUTE_OFS)%CHANNELS
//  CNT_W      16   width of per-channel byte counters
// PORTS
//  clk_i        in   1               app clock
//  rst_i        in   1               async active-high reset
//  out_data_i   in   8*CHANNELS      OUT bytes from usb_cdc; ch i = bits [8i+7:8i]
//  out_valid_i  in   CHANNELS        per-channel OUT byte valid
//  out_ready_o  out  CHANNELS        per-channel OUT byte accepted
//  in_data_o    out  8*CHANNELS      IN bytes to usb_cdc, indexed by destination ch
//  in_valid_o   out  CHANNELS        per-channel IN byte valid
//  in_ready_i   in   CHANNELS        per-channel IN byte taken
//  flush_i      in   CHANNELS        sync flush of the FIFO of source ch i
//  level_o      out  $clog2(DEPTH+1)*CHANNELS  FIFO occupancy per source ch
//  rx_cnt_o     out  CNT_W*CHANNELS  bytes accepted per source ch, wraps to 0
// BEHAVIOUR
//  - Reset (async, rst_i=1): all FIFOs empty, in_valid_o=0, in_data_o=0, level_o=0,
//    rx_cnt_o=0. out_ready_o=1 once reset deasserts (it is ~full).
//  - Push: when out_valid_i[i] & out_ready_o[i] are both high, the byte is written and
//    rx_cnt[i] increments mod 2^CNT_W.
//  - Pop: when in_valid_o[d] & in_ready_i[d] are both high, the head byte is removed.
//    Here d = (i+ROUTE_OFS)%CHANNELS.
//  - FIFO is first-word-fall-through with a registered head.
//    A byte pushed into an empty FIFO at edge N gives in_valid_o=1 after edge N+1.
//    Latency is 1 cycle.
//  - Throughput is 1 byte/clk per channel when both sides stream.
//  - out_ready_o[i] = (level<DEPTH). It is combinational from registered state only,
//    with no path from in_ready_i.
//  - Full FIFO with a pop in the same cycle: the pop only; no push (ready was low).
//  - Empty FIFO with a push in the same cycle: the push only; no pop (valid was low).
//  - Simultaneous push and pop at 0<level<DEPTH: level is unchanged.
//  - Read and write pointers are log2(DEPTH) bits wide and wrap naturally.
//    level is tracked separately, 0..DEPTH.
//  - flush_i[i] has priority over push and pop in the same cycle.
//    It sets level=0, in_valid_o[d]=0 and pointers=0. rx_cnt is not cleared.
//    A byte offered that cycle is not accepted, so out_ready_o is forced 0 during flush.
//  - in_data_o is held stable while in_valid_o=1 and in_ready_i=0.
//  - Reset mid-transfer drops all buffered bytes. There is no partial-state recovery.
// CONFIGURATION
//  Macro LOOPBACK_XFORM_EN
//  - Defined: each byte is transformed on push.
//    'A'..'Z' become lowercase. '0'..'8' become +1. '9' becomes '0'. Others pass unchanged.
//  - Undefined: pure byte echo. The transform logic is absent.
//  - level_o, rx_cnt_o and latency are identical in both builds.
// STRUCTURE
//  - Shared package loopback_pkg: ASCII boundary constants, the xform function,
//    and a clog2 function.
//  - Sub-module loopback_fifo: one-channel FWFT FIFO with flush and level.
//    Instantiated CHANNELS times in a generate loop.
//  - The top level holds the routing permutation, the xform and the counters.
// TESTING
//  - Reset then idle: out_ready_o=all 1, in_valid_o=0, level_o=0, rx_cnt_o=0.
//  - CH0, ROUTE_OFS=0, push 01..07:
//    IN ch0 returns 01..07 in order, first valid 1 clk after first push.
//    rx_cnt[0]=7.
//  - Push 24 bytes "ABCDEFGH QRSTUVWX abcdefgh" with in_ready=0:
//    out_ready drops after byte 16, level=16.
//    Draining gives "abcdefgh qrstuvwx" (XFORM_EN) or "ABCDEFGH QRSTUVWX" (no XFORM_EN).
//  - XFORM_EN, push "12345678" -> IN "23456789". '9' -> '0'. 0x21 -> 0x21.
//  - CHANNELS=2, ROUTE_OFS=1:
//    OUT ch0 bytes appear only on IN ch1, OUT ch1 bytes only on IN ch0.
//    Concurrent full-rate streams show no loss.
//  - level=5 with push and pop in the same cycle: level stays 5.
//    Asserting flush_i with out_valid high: level=0, byte not accepted, rx_cnt unchanged.

Source files
------------

// File: rtl/loopback_pkg.sv
// Shared definitions for the multi-channel loopback engine: ASCII boundary
// constants, the optional byte transform and a constant-capable clog2.
package loopback_pkg;

  localparam logic [7:0] ASCII_UC_A  = 8'h41;
  localparam logic [7:0] ASCII_UC_Z  = 8'h5A;
  localparam logic [7:0] ASCII_D0    = 8'h30;
  localparam logic [7:0] ASCII_D8    = 8'h38;
  localparam logic [7:0] ASCII_D9    = 8'h39;
  localparam logic [7:0] ASCII_LC_OR = 8'h20;

  // Upper-case letters fold to lower case, digits rotate by one ('9' wraps to '0').
  function automatic logic [7:0] xform(input logic [7:0] b);
    if (b >= ASCII_UC_A && b <= ASCII_UC_Z) return b | ASCII_LC_OR;
    if (b >= ASCII_D0 && b <= ASCII_D8)     return b + 8'd1;
    if (b == ASCII_D9)                      return ASCII_D0;
    return b;
  endfunction

  // Smallest r with 2**r >= v; usable in parameter/port-width expressions.
  function automatic int clog2(input int v);
    for (int r = 0; r < 31; r++) begin
      if ((1 << r) >= v) return r;
    end
    return 31;
  endfunction

endpackage

// File: rtl/loopback_fifo.sv
// One-channel first-word-fall-through byte FIFO with a registered head,
// synchronous flush and an occupancy count that includes the head byte.
module loopback_fifo
  import loopback_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LW    = clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush,
  input  logic          wr_valid,
  input  logic [7:0]    wr_data,
  output logic          wr_ready,
  output logic          rd_valid,
  output logic [7:0]    rd_data,
  input  logic          rd_ready,
  output logic [LW-1:0] level
);

  localparam int AW = clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [LW-1:0] lvl;
  logic [LW-1:0] avail;
  logic          push;
  logic          pop;
  logic          head_vld_p1;
  logic [7:0]    head_data_p1;

  // Ready depends only on registered occupancy; flush refuses the offered byte.
  assign wr_ready = (lvl < LW'(DEPTH)) & ~flush;
  assign push     = wr_valid & wr_ready;
  assign pop      = head_vld_p1 & rd_ready & ~flush;
  // Bytes already in storage from the post-pop read pointer onward.
  assign rd_nxt   = rd_ptr + AW'(pop);
  assign avail    = lvl - LW'(pop);

  // Storage array write port; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and the registered head byte.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      lvl          <= '0;
      head_vld_p1  <= 1'b0;
      head_data_p1 <= '0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      lvl          <= '0;
      head_vld_p1  <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + AW'(push);
      rd_ptr      <= rd_nxt;
      lvl         <= lvl + LW'(push) - LW'(pop);
      head_vld_p1 <= (avail != '0);
      if (avail != '0) head_data_p1 <= mem[rd_nxt];
    end
  end

  assign rd_valid = head_vld_p1;
  assign rd_data  = head_data_p1;
  assign level    = lvl;

endmodule

// File: rtl/loopback_mch.sv
// Multi-channel application-side loopback engine. OUT channel i is buffered
// in its own FIFO and returned on IN channel (i+ROUTE_OFS)%CHANNELS.
// Optional feature: define LOOPBACK_XFORM_EN to transform each byte on push
// (letters to lower case, digits rotated); otherwise bytes echo unchanged.
module loopback_mch
  import loopback_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int DEPTH     = 16,
  parameter int ROUTE_OFS = 0,
  parameter int CNT_W     = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [8*CHANNELS-1:0]                 out_data_i,
  input  logic [CHANNELS-1:0]                   out_valid_i,
  output logic [CHANNELS-1:0]                   out_ready_o,
  output logic [8*CHANNELS-1:0]                 in_data_o,
  output logic [CHANNELS-1:0]                   in_valid_o,
  input  logic [CHANNELS-1:0]                   in_ready_i,
  input  logic [CHANNELS-1:0]                   flush_i,
  output logic [clog2(DEPTH+1)*CHANNELS-1:0]    level_o,
  output logic [CNT_W*CHANNELS-1:0]             rx_cnt_o
);

  localparam int LW = clog2(DEPTH + 1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam int D = (i + ROUTE_OFS) % CHANNELS;

    logic [7:0]       raw;
    logic [7:0]       wdata;
    logic             wr_ready;
    logic [CNT_W-1:0] rx_cnt;

    assign raw = out_data_i[8*i +: 8];
`ifdef LOOPBACK_XFORM_EN
    assign wdata = xform(raw);
`else
    assign wdata = raw;
`endif

    loopback_fifo #(
      .DEPTH (DEPTH),
      .LW    (LW)
    ) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .flush    (flush_i[i]),
      .wr_valid (out_valid_i[i]),
      .wr_data  (wdata),
      .wr_ready (wr_ready),
      .rd_valid (in_valid_o[D]),
      .rd_data  (in_data_o[8*D +: 8]),
      .rd_ready (in_ready_i[D]),
      .level    (level_o[LW*i +: LW])
    );

    assign out_ready_o[i] = wr_ready;

    // Count accepted OUT bytes; wraps naturally and survives flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rx_cnt <= '0;
      end else if (out_valid_i[i] & wr_ready) begin
        rx_cnt <= rx_cnt + CNT_W'(1);
      end
    end

    assign rx_cnt_o[CNT_W*i +: CNT_W] = rx_cnt;
  end

endmodule

// File: tb/tb_loopback_mch.sv
// Directed bench for loopback_mch (CHANNELS=2, DEPTH=16, ROUTE_OFS=1) with
// a per-IN-channel scoreboard filled at push time and drained by a monitor.
module tb_loopback_mch;

  localparam int CH  = 2;
  localparam int DEP = 16;
  localparam int LW  = 5;
  localparam int CW  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [8*CH-1:0]   out_data = '0;
  logic [CH-1:0]     out_valid = '0;
  logic [CH-1:0]     out_ready;
  logic [8*CH-1:0]   in_data;
  logic [CH-1:0]     in_valid;
  logic [CH-1:0]     in_ready = '0;
  logic [CH-1:0]     flush = '0;
  logic [LW*CH-1:0]  level;
  logic [CW*CH-1:0]  rx_cnt;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [CW-1:0] rx_exp [CH];
  int          stalls;

  loopback_mch #(
    .CHANNELS  (CH),
    .DEPTH     (DEP),
    .ROUTE_OFS (1),
    .CNT_W     (CW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .out_data_i  (out_data),
    .out_valid_i (out_valid),
    .out_ready_o (out_ready),
    .in_data_o   (in_data),
    .in_valid_o  (in_valid),
    .in_ready_i  (in_ready),
    .flush_i     (flush),
    .level_o     (level),
    .rx_cnt_o    (rx_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mdl(input logic [7:0] b);
`ifdef LOOPBACK_XFORM_EN
    if (b inside {[8'h41:8'h5A]}) return b + 8'h20;
    if (b inside {[8'h30:8'h38]}) return b + 8'h01;
    if (b == 8'h39) return 8'h30;
`endif
    return b;
  endfunction

  task automatic sb_push(input int ch, input logic [7:0] b);
    if (ch == 0) q1.push_back(mdl(b));
    else         q0.push_back(mdl(b));
    rx_exp[ch] = rx_exp[ch] + 1'b1;
  endtask

  task automatic push_byte(input int ch, input logic [7:0] b);
    bit ok = 1'b0;
    out_data[8*ch +: 8] = b;
    out_valid[ch] = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (out_ready[ch]) begin ok = 1'b1; break; end
    end
    if (!ok) check("push_timeout", 32'd0, 32'd1);
    else sb_push(ch, b);
    @(posedge clk); #1;
    out_valid[ch] = 1'b0;
  endtask

  task automatic push_pair(input logic [7:0] b0, input logic [7:0] b1);
    bit ok = 1'b0;
    out_data  = {b1, b0};
    out_valid = 2'b11;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (out_ready == 2'b11) begin ok = 1'b1; break; end
      stalls++;
    end
    if (!ok) check("pair_timeout", 32'd0, 32'd1);
    else begin sb_push(0, b0); sb_push(1, b1); end
    @(posedge clk); #1;
    out_valid = 2'b00;
  endtask

  // Monitor: a handshake visible at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid[0] && in_ready[0]) begin
        if (q0.size() == 0) check("in0_unexpected", 32'd1, 32'd0);
        else check("in0_data", {24'd0, in_data[7:0]}, {24'd0, q0.pop_front()});
      end
      if (in_valid[1] && in_ready[1]) begin
        if (q1.size() == 0) check("in1_unexpected", 32'd1, 32'd0);
        else check("in1_data", {24'd0, in_data[15:8]}, {24'd0, q1.pop_front()});
      end
    end
  end

  initial begin
    logic [7:0] s16 [16];
    logic [7:0] xs  [10];
    rx_exp[0] = '0;
    rx_exp[1] = '0;
    s16 = '{8'h41,8'h42,8'h43,8'h44,8'h45,8'h46,8'h47,8'h48,
            8'h51,8'h52,8'h53,8'h54,8'h55,8'h56,8'h57,8'h58};
    xs  = '{8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,8'h21};

    // Reset then idle
    repeat (3) @(negedge clk);
    check("rst_in_valid", {30'd0, in_valid}, 32'd0);
    check("rst_in_data", {16'd0, in_data}, 32'd0);
    check("rst_level", {22'd0, level}, 32'd0);
    check("rst_rx_cnt", rx_cnt, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_out_ready", {30'd0, out_ready}, 32'd3);
    check("idle_in_valid", {30'd0, in_valid}, 32'd0);
    @(posedge clk); #1;

    // OUT ch0 bytes 01..07 return on IN ch1, first valid one clock after accept
    in_ready = 2'b11;
    push_byte(0, 8'h01);
    @(negedge clk);
    check("lat_not_yet", {31'd0, in_valid[1]}, 32'd0);
    check("lat_route_ch0", {31'd0, in_valid[0]}, 32'd0);
    @(negedge clk);
    check("lat_valid", {31'd0, in_valid[1]}, 32'd1);
    @(posedge clk); #1;
    for (int k = 2; k <= 7; k++) push_byte(0, 8'(k));
    repeat (5) @(negedge clk);
    check("seq_drained", q1.size(), 32'd0);
    check("seq_rx_cnt0", {16'd0, rx_cnt[15:0]}, 32'd7);
    check("seq_level0", {27'd0, level[4:0]}, 32'd0);
    @(posedge clk); #1;

    // Fill ch0 with IN side stalled; ready drops at 16 and byte 17 is refused
    in_ready = 2'b00;
    for (int k = 0; k < 16; k++) push_byte(0, s16[k]);
    @(negedge clk);
    check("full_level", {27'd0, level[4:0]}, 32'd16);
    check("full_ready", {31'd0, out_ready[0]}, 32'd0);
    @(posedge clk); #1;
    out_data[7:0] = 8'h61;
    out_valid[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("full_refuse_cnt", {16'd0, rx_cnt[15:0]}, 32'd23);
    check("full_refuse_lvl", {27'd0, level[4:0]}, 32'd16);
    @(posedge clk); #1;
    out_valid[0] = 1'b0;
    in_ready = 2'b11;
    repeat (20) @(negedge clk);
    check("full_drained", q1.size(), 32'd0);
    check("full_level_0", {27'd0, level[4:0]}, 32'd0);
    @(posedge clk); #1;

    // Digit rotation, '9' wrap and pass-through of punctuation
    for (int k = 0; k < 10; k++) push_byte(0, xs[k]);
    repeat (4) @(negedge clk);
    check("xform_drained", q1.size(), 32'd0);
    @(posedge clk); #1;

    // Concurrent full-rate streams on both channels, crossed routing
    stalls = 0;
    for (int k = 0; k < 24; k++) push_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    check("stream_stalls", stalls, 32'd0);
    repeat (5) @(negedge clk);
    check("stream_q0", q0.size(), 32'd0);
    check("stream_q1", q1.size(), 32'd0);
    check("stream_cnt0", {16'd0, rx_cnt[15:0]}, {16'd0, rx_exp[0]});
    check("stream_cnt1", {16'd0, rx_cnt[31:16]}, {16'd0, rx_exp[1]});
    @(posedge clk); #1;

    // Level 5 on ch1 with simultaneous push and pop
    in_ready = 2'b00;
    for (int k = 0; k < 5; k++) push_byte(1, 8'(8'h40 + k));
    @(negedge clk);
    check("lvl5_before", {27'd0, level[9:5]}, 32'd5);
    @(posedge clk); #1;
    in_ready[0] = 1'b1;
    push_byte(1, 8'h4A);
    in_ready[0] = 1'b0;
    @(negedge clk);
    check("lvl5_after", {27'd0, level[9:5]}, 32'd5);
    @(posedge clk); #1;

    // Flush ch1 while a byte is offered
    out_data[15:8] = 8'h55;
    out_valid[1] = 1'b1;
    flush[1] = 1'b1;
    @(negedge clk);
    check("flush_ready", {31'd0, out_ready[1]}, 32'd0);
    @(posedge clk); #1;
    flush[1] = 1'b0;
    out_valid[1] = 1'b0;
    @(negedge clk);
    check("flush_level", {27'd0, level[9:5]}, 32'd0);
    check("flush_valid", {31'd0, in_valid[0]}, 32'd0);
    check("flush_cnt", {16'd0, rx_cnt[31:16]}, {16'd0, rx_exp[1]});
    q0.delete();
    @(posedge clk); #1;
    in_ready = 2'b11;
    push_byte(1, 8'h7A);
    repeat (3) @(negedge clk);
    check("post_flush_q0", q0.size(), 32'd0);
    @(posedge clk); #1;

    // Reset mid-transfer drops everything
    in_ready = 2'b00;
    for (int k = 0; k < 3; k++) push_byte(0, 8'(8'h30 + k));
    rst = 1'b1;
    @(negedge clk);
    check("mrst_level", {22'd0, level}, 32'd0);
    check("mrst_valid", {30'd0, in_valid}, 32'd0);
    check("mrst_cnt", rx_cnt, 32'd0);
    q1.delete();
    rx_exp[0] = '0;
    rx_exp[1] = '0;
    rst = 1'b0;
    @(negedge clk);
    check("mrst_ready", {30'd0, out_ready}, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
